// File: rtl/sdram_burst_scheduler.sv
// Burst scheduler for the SDRAM frame-buffer path: picks the next read/write FIFO port,
// keeps per-port circular address pointers and runs one REQ/ACK/DONE burst at a time.
module sdram_burst_scheduler #(
   parameter int unsigned NRD     = 2,
   parameter int unsigned NWR     = 2,
   parameter int unsigned ASIZE   = 22,
   parameter int unsigned LSIZE   = 9,
   parameter int unsigned USIZE   = 16,
   parameter int unsigned RR_MODE = 0
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [NRD*USIZE-1:0]   RD_LEVEL,
   input  logic [NRD*ASIZE-1:0]   RD_BASE,
   input  logic [NRD*ASIZE-1:0]   RD_MAX,
   input  logic [NRD*LSIZE-1:0]   RD_LENGTH,
   input  logic [NRD-1:0]         RD_LOAD,
   input  logic [NWR*USIZE-1:0]   WR_LEVEL,
   input  logic [NWR*ASIZE-1:0]   WR_BASE,
   input  logic [NWR*ASIZE-1:0]   WR_MAX,
   input  logic [NWR*LSIZE-1:0]   WR_LENGTH,
   input  logic [NWR-1:0]         WR_LOAD,
   output logic                   REQ,
   output logic                   REQ_WRITE,
   output logic [ASIZE-1:0]       REQ_ADDR,
   output logic [LSIZE-1:0]       REQ_LENGTH,
   input  logic                   ACK,
   input  logic                   DONE,
   output logic [NRD-1:0]         RD_MASK,
   output logic [NWR-1:0]         WR_MASK,
   output logic                   BUSY,
   output logic [15:0]            GRANT_CNT
);

   localparam int unsigned N  = NRD + NWR;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (USIZE > LSIZE) ? USIZE : LSIZE;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StUpdate} state_e;

   state_e             state_q, state_d;
   logic               init_q, init_d;
   logic [ASIZE-1:0]   ptr_q [N];
   logic [ASIZE-1:0]   ptr_d [N];
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      last_q, last_d;
   logic [ASIZE-1:0]   req_addr_q, req_addr_d;
   logic [LSIZE-1:0]   req_len_q, req_len_d;
   logic               req_write_q, req_write_d;
   logic [N-1:0]       mask_q, mask_d;
   logic [15:0]        cnt_q, cnt_d;

   // Ports flattened into one ring: slots 0..NRD-1 are reads, the rest writes.
   logic [ASIZE-1:0]   base_a [N];
   logic [ASIZE-1:0]   max_a [N];
   logic [LSIZE-1:0]   len_a [N];
   logic [N-1:0]       elig;
   logic [N-1:0]       load_a;
   logic               win_found;
   logic [IW-1:0]      win_idx;
   logic [IW-1:0]      slot;
   logic [ASIZE-1:0]   cur_ptr;

   always_comb begin
      elig   = '0;
      load_a = '0;
      for (int k = 0; k < N; k++) begin
         base_a[k] = '0;
         max_a[k]  = '0;
         len_a[k]  = '0;
      end
      for (int i = 0; i < NRD; i++) begin
         base_a[i] = RD_BASE[i*ASIZE +: ASIZE];
         max_a[i]  = RD_MAX[i*ASIZE +: ASIZE];
         len_a[i]  = RD_LENGTH[i*LSIZE +: LSIZE];
         load_a[i] = RD_LOAD[i];
         elig[i]   = (len_a[i] != '0) && !RD_LOAD[i] &&
                     (CW'(RD_LEVEL[i*USIZE +: USIZE]) < CW'(len_a[i]));
      end
      for (int j = 0; j < NWR; j++) begin
         base_a[NRD+j] = WR_BASE[j*ASIZE +: ASIZE];
         max_a[NRD+j]  = WR_MAX[j*ASIZE +: ASIZE];
         len_a[NRD+j]  = WR_LENGTH[j*LSIZE +: LSIZE];
         load_a[NRD+j] = WR_LOAD[j];
         elig[NRD+j]   = (len_a[NRD+j] != '0) && !WR_LOAD[j] &&
                         (CW'(WR_LEVEL[j*USIZE +: USIZE]) >= CW'(len_a[NRD+j]));
      end
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      slot      = '0;
      if (RR_MODE == 0) begin
         for (int k = 0; k < N; k++) begin
            if (!win_found && elig[k]) begin
               win_found = 1'b1;
               win_idx   = IW'(k);
            end
         end
      end else begin
         for (int off = 1; off <= N; off++) begin
            slot = IW'((32'(last_q) + 32'(off)) % N);
            if (!win_found && elig[slot]) begin
               win_found = 1'b1;
               win_idx   = slot;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      init_d      = 1'b1;
      gidx_d      = gidx_q;
      last_d      = last_q;
      req_addr_d  = req_addr_q;
      req_len_d   = req_len_q;
      req_write_d = req_write_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      cur_ptr     = ptr_q[gidx_q];
      for (int k = 0; k < N; k++) ptr_d[k] = ptr_q[k];

      unique case (state_q)
         StIdle: begin
            // No grant until the pointers have picked up their BASE values.
            if (init_q && win_found) begin
               gidx_d      = win_idx;
               last_d      = win_idx;
               req_addr_d  = ptr_q[win_idx];
               req_len_d   = len_a[win_idx];
               req_write_d = (32'(win_idx) >= NRD);
               mask_d      = N'(1) << win_idx;
               state_d     = StReq;
            end
         end
         StReq: begin
            if (ACK) state_d = StWait;
         end
         StWait: begin
            if (DONE) state_d = StUpdate;
         end
         StUpdate: begin
            if (cur_ptr < max_a[gidx_q] - ASIZE'(req_len_q)) begin
               ptr_d[gidx_q] = cur_ptr + ASIZE'(req_len_q);
            end else begin
               ptr_d[gidx_q] = base_a[gidx_q];
            end
            mask_d  = '0;
            cnt_d   = cnt_q + 16'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A reload overrides any advance from the burst just completed.
      for (int k = 0; k < N; k++) begin
         if (!init_q || load_a[k]) ptr_d[k] = base_a[k];
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         init_q      <= 1'b0;
         gidx_q      <= '0;
         last_q      <= IW'(N - 1);
         req_addr_q  <= '0;
         req_len_q   <= '0;
         req_write_q <= 1'b0;
         mask_q      <= '0;
         cnt_q       <= '0;
         for (int k = 0; k < N; k++) ptr_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         gidx_q      <= gidx_d;
         last_q      <= last_d;
         req_addr_q  <= req_addr_d;
         req_len_q   <= req_len_d;
         req_write_q <= req_write_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         for (int k = 0; k < N; k++) ptr_q[k] <= ptr_d[k];
      end
   end

   assign REQ        = (state_q == StReq);
   assign BUSY       = (state_q != StIdle);
   assign REQ_WRITE  = req_write_q;
   assign REQ_ADDR   = req_addr_q;
   assign REQ_LENGTH = req_len_q;
   assign RD_MASK    = mask_q[NRD-1:0];
   assign WR_MASK    = mask_q[N-1:NRD];
   assign GRANT_CNT  = cnt_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler: a fixed-priority instance under hand-driven
// ACK/DONE and a round-robin instance answered by a simple command-engine responder.
module tb_sdram_burst_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rd_level, wr_level;
   logic [43:0] rd_base, rd_max, wr_base, wr_max;
   logic [17:0] rd_length, wr_length;
   logic [1:0]  rd_load, wr_load;
   logic        ack, done, ack_rr, done_rr;

   logic        req, req_write, busy;
   logic [21:0] req_addr;
   logic [8:0]  req_length;
   logic [1:0]  rd_mask, wr_mask;
   logic [15:0] grant_cnt;

   logic        rr_req, rr_req_write, rr_busy;
   logic [21:0] rr_req_addr;
   logic [8:0]  rr_req_length;
   logic [1:0]  rr_rd_mask, rr_wr_mask;
   logic [15:0] rr_grant_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [21:0] cap_addr;
   logic [8:0]  cap_len;
   logic        cap_write;
   logic [1:0]  cap_rd, cap_wr;
   logic        rr_en = 1'b0;
   logic        rr_pending;
   logic [3:0]  rr_mask_log [$];
   logic [21:0] rr_addr_log [$];
   logic [8:0]  rr_len_log [$];

   always #5 clk = ~clk;

   sdram_burst_scheduler #(.RR_MODE(0)) dut (
      .CLK(clk), .RESET_N(rst_n),
      .RD_LEVEL(rd_level), .RD_BASE(rd_base), .RD_MAX(rd_max), .RD_LENGTH(rd_length),
      .RD_LOAD(rd_load),
      .WR_LEVEL(wr_level), .WR_BASE(wr_base), .WR_MAX(wr_max), .WR_LENGTH(wr_length),
      .WR_LOAD(wr_load),
      .REQ(req), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_LENGTH(req_length),
      .ACK(ack), .DONE(done), .RD_MASK(rd_mask), .WR_MASK(wr_mask), .BUSY(busy),
      .GRANT_CNT(grant_cnt)
   );

   sdram_burst_scheduler #(.RR_MODE(1)) dut_rr (
      .CLK(clk), .RESET_N(rst_n),
      .RD_LEVEL(rd_level), .RD_BASE(rd_base), .RD_MAX(rd_max), .RD_LENGTH(rd_length),
      .RD_LOAD(rd_load),
      .WR_LEVEL(wr_level), .WR_BASE(wr_base), .WR_MAX(wr_max), .WR_LENGTH(wr_length),
      .WR_LOAD(wr_load),
      .REQ(rr_req), .REQ_WRITE(rr_req_write), .REQ_ADDR(rr_req_addr),
      .REQ_LENGTH(rr_req_length), .ACK(ack_rr), .DONE(done_rr), .RD_MASK(rr_rd_mask),
      .WR_MASK(rr_wr_mask), .BUSY(rr_busy), .GRANT_CNT(rr_grant_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int i, input logic [21:0] b, input logic [21:0] m,
                         input logic [8:0] l, input logic [15:0] lv);
      rd_base[i*22 +: 22]  = b;
      rd_max[i*22 +: 22]   = m;
      rd_length[i*9 +: 9]  = l;
      rd_level[i*16 +: 16] = lv;
   endtask

   task automatic set_wr(input int i, input logic [21:0] b, input logic [21:0] m,
                         input logic [8:0] l, input logic [15:0] lv);
      wr_base[i*22 +: 22]  = b;
      wr_max[i*22 +: 22]   = m;
      wr_length[i*9 +: 9]  = l;
      wr_level[i*16 +: 16] = lv;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!req && n < 20);
      if (!req) check_eq("req_timeout", 32'(req), 1);
      cap_addr  = req_addr;
      cap_len   = req_length;
      cap_write = req_write;
      cap_rd    = rd_mask;
      cap_wr    = wr_mask;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic do_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic run_burst();
      int n;
      wait_req(n);
      do_ack();
      do_done();
      tick();
   endtask

   // Command engine for the round-robin instance: ACK at once, DONE one cycle later.
   initial begin
      ack_rr = 1'b0;
      done_rr = 1'b0;
      rr_pending = 1'b0;
      forever begin
         tick();
         ack_rr = 1'b0;
         done_rr = 1'b0;
         if (!rst_n) begin
            rr_pending = 1'b0;
         end else if (rr_req) begin
            ack_rr = 1'b1;
            rr_pending = 1'b1;
            if (rr_en) begin
               rr_mask_log.push_back({rr_wr_mask, rr_rd_mask});
               rr_addr_log.push_back(rr_req_addr);
               rr_len_log.push_back(rr_req_length);
            end
         end else if (rr_pending && rr_busy) begin
            done_rr = 1'b1;
            rr_pending = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [21:0] wrap_exp [5];
      logic [3:0]  rr_exp_mask [5];
      logic [21:0] rr_exp_addr [5];
      wrap_exp    = '{22'h000, 22'h100, 22'h200, 22'h300, 22'h000};
      rr_exp_mask = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_exp_addr = '{22'h800, 22'h1800, 22'h2000, 22'h3000, 22'h840};

      rst_n = 1'b0;
      ack = 1'b0;
      done = 1'b0;
      rd_load = '0;
      wr_load = '0;
      set_rd(0, 22'h1000, 22'h100000, 9'd256, 16'd0);
      set_rd(1, 22'h1800, 22'h100000, 9'd0, 16'd0);
      set_wr(0, 22'h2000, 22'h100000, 9'd0, 16'd0);
      set_wr(1, 22'h3000, 22'h100000, 9'd0, 16'd0);

      #12;
      check_eq("rst_req", 32'(req), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_rd_mask", 32'(rd_mask), 0);
      check_eq("rst_wr_mask", 32'(wr_mask), 0);
      check_eq("rst_grant_cnt", 32'(grant_cnt), 0);
      check_eq("rst_req_addr", 32'(req_addr), 0);
      #10 rst_n = 1'b1;

      // Single read burst on RD0
      wait_req(n);
      check_eq("t1_write", 32'(cap_write), 0);
      check_eq("t1_addr", 32'(cap_addr), 'h1000);
      check_eq("t1_len", 32'(cap_len), 256);
      check_eq("t1_rd_mask", 32'(cap_rd), 1);
      check_eq("t1_wr_mask", 32'(cap_wr), 0);
      check_eq("t1_busy", 32'(busy), 1);
      do_ack();
      check_eq("t1_wait_req", 32'(req), 0);
      check_eq("t1_wait_mask", 32'(rd_mask), 1);
      do_done();
      check_eq("t1_update_busy", 32'(busy), 1);
      tick();
      check_eq("t1_idle_busy", 32'(busy), 0);
      check_eq("t1_idle_mask", 32'(rd_mask), 0);
      check_eq("t1_grant_cnt", 32'(grant_cnt), 1);
      wait_req(n);
      check_eq("t1_rearb_latency", 32'(n), 1);
      check_eq("t1_ptr_advanced", 32'(cap_addr), 'h1100);
      do_ack();
      do_done();
      tick();
      check_eq("t1_grant_cnt2", 32'(grant_cnt), 2);

      // Circular pointer wrap
      set_rd(0, 22'h0, 22'h400, 9'h100, 16'd0);
      rd_load[0] = 1'b1;
      tick();
      rd_load[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run_burst();
         check_eq($sformatf("wrap_addr%0d", i), 32'(cap_addr), 32'(wrap_exp[i]));
      end
      rd_length[8:0] = 9'd0;
      check_eq("wrap_grant_cnt", 32'(grant_cnt), 7);

      // Delayed ACK, spurious DONE in REQ, input change after grant
      rd_length[8:0] = 9'h100;
      wait_req(n);
      check_eq("dly_addr", 32'(cap_addr), 'h100);
      for (int i = 0; i < 10; i++) begin
         done = (i == 4);
         if (i == 2) rd_length[8:0] = 9'h080;
         tick();
         check_eq($sformatf("dly_req%0d", i), 32'(req), 1);
         check_eq($sformatf("dly_addr%0d", i), 32'(req_addr), 'h100);
         check_eq($sformatf("dly_len%0d", i), 32'(req_length), 'h100);
      end
      done = 1'b0;
      do_ack();
      check_eq("dly_req_drop", 32'(req), 0);
      tick();
      tick();
      check_eq("dly_wait_mask", 32'(rd_mask), 1);
      check_eq("dly_wait_busy", 32'(busy), 1);
      do_done();
      tick();
      rd_length[8:0] = 9'd0;
      check_eq("dly_grant_cnt", 32'(grant_cnt), 8);

      // WR_LOAD1 during a WR1 burst; RD0 still served while WR1 is held in load
      set_wr(1, 22'h3000, 22'h100000, 9'd16, 16'd20);
      wait_req(n);
      check_eq("ld_write", 32'(cap_write), 1);
      check_eq("ld_addr", 32'(cap_addr), 'h3000);
      check_eq("ld_wr_mask", 32'(cap_wr), 2);
      check_eq("ld_rd_mask", 32'(cap_rd), 0);
      do_ack();
      wr_load[1] = 1'b1;
      set_rd(0, 22'h800, 22'h100000, 9'h40, 16'd0);
      rd_load[0] = 1'b1;
      tick();
      rd_load[0] = 1'b0;
      check_eq("ld_wait_wr_mask", 32'(wr_mask), 2);
      do_done();
      tick();
      check_eq("ld_wr_mask_clr", 32'(wr_mask), 0);
      check_eq("ld_grant_cnt", 32'(grant_cnt), 9);
      wait_req(n);
      check_eq("ld_rd0_mask", 32'(cap_rd), 1);
      check_eq("ld_rd0_write", 32'(cap_write), 0);
      check_eq("ld_rd0_addr", 32'(cap_addr), 'h800);
      do_ack();
      do_done();
      tick();
      rd_length[8:0] = 9'd0;
      wr_load[1] = 1'b0;
      wait_req(n);
      check_eq("ld_wr1_mask", 32'(cap_wr), 2);
      check_eq("ld_wr1_addr_base", 32'(cap_addr), 'h3000);
      do_ack();
      do_done();
      tick();
      wr_length[17:9] = 9'd0;
      check_eq("ld_grant_cnt2", 32'(grant_cnt), 11);

      // Asynchronous reset in WAIT
      rd_length[8:0] = 9'h40;
      wait_req(n);
      check_eq("ar_addr", 32'(cap_addr), 'h840);
      do_ack();
      #3 rst_n = 1'b0;
      #1;
      check_eq("ar_req", 32'(req), 0);
      check_eq("ar_rd_mask", 32'(rd_mask), 0);
      check_eq("ar_wr_mask", 32'(wr_mask), 0);
      check_eq("ar_busy", 32'(busy), 0);
      check_eq("ar_grant_cnt", 32'(grant_cnt), 0);

      // All four ports eligible: fixed keeps picking RD0, round-robin walks the ring
      set_rd(1, 22'h1800, 22'h100000, 9'h40, 16'd0);
      set_wr(0, 22'h2000, 22'h100000, 9'h40, 16'h40);
      set_wr(1, 22'h3000, 22'h100000, 9'h40, 16'h40);
      rr_mask_log.delete();
      rr_addr_log.delete();
      rr_len_log.delete();
      rr_en = 1'b1;
      tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_burst();
         check_eq($sformatf("fx_rd_mask%0d", i), 32'(cap_rd), 1);
         check_eq($sformatf("fx_addr%0d", i), 32'(cap_addr), 32'h800 + 32'(i) * 32'h40);
      end
      for (int c = 0; c < 100 && rr_mask_log.size() < 5; c++) tick();
      check_eq("rr_grants_seen", 32'(rr_mask_log.size() >= 5), 1);
      if (rr_mask_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rr_mask%0d", i), 32'(rr_mask_log[i]), 32'(rr_exp_mask[i]));
            check_eq($sformatf("rr_addr%0d", i), 32'(rr_addr_log[i]), 32'(rr_exp_addr[i]));
            check_eq($sformatf("rr_len%0d", i), 32'(rr_len_log[i]), 'h40);
         end
      end
      check_eq("rr_grant_cnt_min", 32'(rr_grant_cnt >= 16'd4), 1);
      check_eq("rr_not_write_first", 32'(rr_req_write && (rr_mask_log.size() == 0)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
